// File: rtl/aes_cbc_ctrl.sv
// CBC-mode sequencer in front of aes_core: loads key/IV, runs key expansion,
// then processes one 128-bit block at a time with chaining XOR and an output buffer.
module aes_cbc_ctrl #(
  parameter bit CBC_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         cfg_load,
  input  logic         cfg_encdec,
  input  logic [127:0] cfg_key,
  input  logic [127:0] cfg_iv,
  output logic         cfg_busy,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         core_encdec,
  output logic         core_init,
  output logic         core_next,
  output logic [127:0] core_key,
  output logic [127:0] core_block,
  input  logic         core_ready,
  input  logic [127:0] core_result
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready
  // are both high; valid never waits on ready, and in_ready drops while cfg_load
  // is high so a configuration load always wins over a block in the same cycle.

  typedef enum logic [2:0] {
    NOKEY = 3'd0,
    KINIT = 3'd1,
    KWAIT = 3'd2,
    RDY   = 3'd3,
    BNEXT = 3'd4,
    BWAIT = 3'd5,
    OUT   = 3'd6
  } state_t;

  state_t       state_q, state_d;
  logic         skip_q;
  logic [127:0] chain_q;
  logic [127:0] saved_q;
  logic [127:0] chain_term;
  logic         cfg_take;
  logic         accept;
  logic         capture;

  assign chain_term = CBC_EN ? chain_q : 128'd0;

  always_comb begin
    state_d   = state_q;
    core_init = 1'b0;
    core_next = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    cfg_busy  = 1'b1;
    cfg_take  = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state_q)
      NOKEY: begin
        cfg_busy = 1'b0;
        if (cfg_load) begin
          cfg_take = 1'b1;
          state_d  = KINIT;
        end
      end
      KINIT: begin
        if (core_ready) begin
          core_init = 1'b1;
          state_d   = KWAIT;
        end
      end
      KWAIT: begin
        if (!skip_q && core_ready) state_d = RDY;
      end
      RDY: begin
        cfg_busy = 1'b0;
        in_ready = !cfg_load;
        if (cfg_load) begin
          cfg_take = 1'b1;
          state_d  = KINIT;
        end else if (in_valid) begin
          accept  = 1'b1;
          state_d = BNEXT;
        end
      end
      BNEXT: begin
        core_next = 1'b1;
        state_d   = BWAIT;
      end
      BWAIT: begin
        if (!skip_q && core_ready) begin
          capture = 1'b1;
          state_d = OUT;
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = RDY;
      end
      default: state_d = NOKEY;
    endcase
  end

  // The core may still show ready in the cycle right after a start pulse,
  // so the wait states ignore core_ready for that one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= NOKEY;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= core_init | core_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_key    <= 128'd0;
      core_encdec <= 1'b0;
      chain_q     <= 128'd0;
      saved_q     <= 128'd0;
      core_block  <= 128'd0;
      out_data    <= 128'd0;
    end else begin
      if (cfg_take) begin
        core_key    <= cfg_key;
        core_encdec <= cfg_encdec;
        if (CBC_EN) chain_q <= cfg_iv;
      end
      if (accept) begin
        saved_q <= in_data;
        if (core_encdec) core_block <= in_data ^ chain_term;
        else             core_block <= in_data;
      end
      if (capture) begin
        if (core_encdec) begin
          out_data <= core_result;
          if (CBC_EN) chain_q <= core_result;
        end else begin
          out_data <= core_result ^ chain_term;
          if (CBC_EN) chain_q <= saved_q;
        end
      end
    end
  end

endmodule
